// File: rtl/register_scoreboard.sv
// register_scoreboard: general-purpose register file with a per-register
// reservation scoreboard. Combinational read ports, optional
// writeback-to-read bypass and optional hardwired-zero register 0.
module register_scoreboard #(
    parameter int LEN_REG    = 32,
    parameter int LEN_REGNO  = 4,
    parameter int NUM_RPORTS = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_RPORTS*LEN_REGNO-1:0] rd_regno_i,
    output logic [NUM_RPORTS*LEN_REG-1:0]   rd_data_o,
    output logic [NUM_RPORTS-1:0]           rd_busy_o,
    input  logic                            rsv_i,
    input  logic [LEN_REGNO-1:0]            rsv_regno_i,
    output logic                            rsv_ok_o,
    input  logic                            wb_i,
    input  logic [LEN_REGNO-1:0]            wb_regno_i,
    input  logic [LEN_REG-1:0]              wb_data_i,
    output logic [2**LEN_REGNO-1:0]         busy_vec_o,
    output logic                            err_o
);

    localparam int unsigned NUM_REGS = 2**LEN_REGNO;
    localparam bit          ZR       = (ZERO_REG != 0);
    localparam bit          BP       = (BYPASS != 0);

    logic [LEN_REG-1:0]  mem_q [NUM_REGS];
    logic [NUM_REGS-1:0] rsv_q;
    logic [NUM_REGS-1:0] rsv_d;
    logic                err_q;
    logic                err_d;

    logic wb_zero;
    logic rsv_zero;
    logic rsv_acc;
    logic wr_en;
    logic wb_err;

    assign wb_zero  = ZR && (wb_regno_i == '0);
    assign rsv_zero = ZR && (rsv_regno_i == '0);
    assign wr_en    = wb_i && !wb_zero;
    assign wb_err   = wb_i && !wb_zero && !rsv_q[wb_regno_i];

    // Reservation is grantable when the register is free, is being released
    // by this cycle's writeback, or is the hardwired zero register.
    assign rsv_ok_o = !rsv_q[rsv_regno_i]
                      || (wb_i && (wb_regno_i == rsv_regno_i))
                      || rsv_zero;
    assign rsv_acc  = rsv_i && rsv_ok_o;

    // Read ports: zero register first, then bypass, then array/scoreboard.
    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rd
        logic [LEN_REGNO-1:0] r;
        logic                 zero_hit;
        logic                 byp_hit;

        assign r        = rd_regno_i[p*LEN_REGNO +: LEN_REGNO];
        assign zero_hit = ZR && (r == '0);
        assign byp_hit  = BP && wb_i && (wb_regno_i == r);

        assign rd_data_o[p*LEN_REG +: LEN_REG] = zero_hit ? '0 :
                                                 byp_hit  ? wb_data_i : mem_q[r];
        assign rd_busy_o[p] = !zero_hit && !byp_hit && rsv_q[r];
    end

    // Next scoreboard state: writeback clears, an accepted reservation sets
    // afterwards so it wins on the same register; register 0 stays free when hardwired.
    always_comb begin
        rsv_d = rsv_q;
        if (wb_i) begin
            rsv_d[wb_regno_i] = 1'b0;
        end
        if (rsv_acc) begin
            rsv_d[rsv_regno_i] = 1'b1;
        end
        if (ZR) begin
            rsv_d[0] = 1'b0;
        end
        err_d = err_q || wb_err;
    end

    // Scoreboard and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsv_q <= '0;
            err_q <= 1'b0;
        end else begin
            rsv_q <= rsv_d;
            err_q <= err_d;
        end
    end

    // Register array write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wb_regno_i] <= wb_data_i;
        end
    end

    assign busy_vec_o = rsv_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard: one instance with default
// parameters (bypass on, no zero register) and one with bypass off and a
// hardwired zero register, both driven by the same stimulus.
module tb_register_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rd_regno;
    logic        rsv_i;
    logic [3:0]  rsv_regno;
    logic        wb_i;
    logic [3:0]  wb_regno;
    logic [31:0] wb_data;

    logic [63:0] rd_data_m, rd_data_a;
    logic [1:0]  rd_busy_m, rd_busy_a;
    logic        rsv_ok_m, rsv_ok_a;
    logic [15:0] busy_vec_m, busy_vec_a;
    logic        err_m, err_a;

    int n_checks = 0;
    int n_fail   = 0;

    register_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .rd_regno_i  (rd_regno),
        .rd_data_o   (rd_data_m),
        .rd_busy_o   (rd_busy_m),
        .rsv_i       (rsv_i),
        .rsv_regno_i (rsv_regno),
        .rsv_ok_o    (rsv_ok_m),
        .wb_i        (wb_i),
        .wb_regno_i  (wb_regno),
        .wb_data_i   (wb_data),
        .busy_vec_o  (busy_vec_m),
        .err_o       (err_m)
    );

    register_scoreboard #(
        .BYPASS   (0),
        .ZERO_REG (1)
    ) dut_alt (
        .clk         (clk),
        .rst         (rst),
        .rd_regno_i  (rd_regno),
        .rd_data_o   (rd_data_a),
        .rd_busy_o   (rd_busy_a),
        .rsv_i       (rsv_i),
        .rsv_regno_i (rsv_regno),
        .rsv_ok_o    (rsv_ok_a),
        .wb_i        (wb_i),
        .wb_regno_i  (wb_regno),
        .wb_data_i   (wb_data),
        .busy_vec_o  (busy_vec_a),
        .err_o       (err_a)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input logic [3:0] p0, input logic [3:0] p1);
        rd_regno = {p1, p0};
    endtask

    initial begin
        rst = 1'b1; rd_regno = '0; rsv_i = 1'b0; rsv_regno = '0;
        wb_i = 1'b0; wb_regno = '0; wb_data = '0;

        // Reset state, rst still high after an edge
        @(negedge clk); #1;
        check("rst_busyvec_m", busy_vec_m, 16'h0000);
        check("rst_busyvec_a", busy_vec_a, 16'h0000);
        check("rst_err_m", err_m, 1'b0);
        check("rst_err_a", err_a, 1'b0);
        check("rst_rsvok_m", rsv_ok_m, 1'b1);
        check("rst_rsvok_a", rsv_ok_a, 1'b1);
        @(negedge clk); rst = 1'b0;

        // Read all 16 registers on both ports
        for (int r = 0; r < 16; r++) begin
            set_rd(4'(r), 4'(15 - r)); #1;
            check("init_data_m", rd_data_m, 64'h0);
            check("init_data_a", rd_data_a, 64'h0);
            check("init_busy_m", rd_busy_m, 2'b00);
            check("init_busy_a", rd_busy_a, 2'b00);
        end

        // Reserve r3
        @(negedge clk);
        rsv_i = 1'b1; rsv_regno = 4'd3; #1;
        check("r3_rsvok_m", rsv_ok_m, 1'b1);
        check("r3_rsvok_a", rsv_ok_a, 1'b1);
        @(negedge clk);
        rsv_i = 1'b0; set_rd(4'd3, 4'd0); #1;
        check("r3_busy_m", rd_busy_m, 2'b01);
        check("r3_busy_a", rd_busy_a, 2'b01);
        check("r3_vec_m", busy_vec_m, 16'h0008);
        check("r3_vec_a", busy_vec_a, 16'h0008);
        rsv_i = 1'b1; #1;
        check("r3_again_ok_m", rsv_ok_m, 1'b0);
        check("r3_again_ok_a", rsv_ok_a, 1'b0);
        @(negedge clk);
        rsv_i = 1'b0; #1;
        check("r3_again_vec_m", busy_vec_m, 16'h0008);
        check("r3_again_vec_a", busy_vec_a, 16'h0008);

        // Writeback r3 with and without bypass
        wb_i = 1'b1; wb_regno = 4'd3; wb_data = 32'hDEADBEEF; #1;
        check("wb3_byp_data_m", rd_data_m[31:0], 32'hDEADBEEF);
        check("wb3_byp_busy_m", rd_busy_m[0], 1'b0);
        check("wb3_nobyp_data_a", rd_data_a[31:0], 32'h0);
        check("wb3_nobyp_busy_a", rd_busy_a[0], 1'b1);
        check("wb3_rsvok_m", rsv_ok_m, 1'b1);
        check("wb3_rsvok_a", rsv_ok_a, 1'b1);
        @(negedge clk);
        wb_i = 1'b0; #1;
        check("wb3_after_data_m", rd_data_m[31:0], 32'hDEADBEEF);
        check("wb3_after_data_a", rd_data_a[31:0], 32'hDEADBEEF);
        check("wb3_after_vec_m", busy_vec_m, 16'h0000);
        check("wb3_after_vec_a", busy_vec_a, 16'h0000);
        check("wb3_after_err_m", err_m, 1'b0);

        // r5: writeback and new reservation in the same cycle
        rsv_i = 1'b1; rsv_regno = 4'd5;
        @(negedge clk);
        wb_i = 1'b1; wb_regno = 4'd5; wb_data = 32'h12345678; #1;
        check("r5_pre_vec_m", busy_vec_m, 16'h0020);
        check("r5_pre_vec_a", busy_vec_a, 16'h0020);
        check("r5_rsvok_m", rsv_ok_m, 1'b1);
        check("r5_rsvok_a", rsv_ok_a, 1'b1);
        @(negedge clk);
        rsv_i = 1'b0; wb_i = 1'b0; set_rd(4'd5, 4'd3); #1;
        check("r5_data_m", rd_data_m, {32'hDEADBEEF, 32'h12345678});
        check("r5_data_a", rd_data_a, {32'hDEADBEEF, 32'h12345678});
        check("r5_vec_m", busy_vec_m, 16'h0020);
        check("r5_vec_a", busy_vec_a, 16'h0020);
        check("r5_rdbusy_m", rd_busy_m, 2'b01);
        check("r5_err_m", err_m, 1'b0);
        check("r5_err_a", err_a, 1'b0);
        wb_i = 1'b1; wb_data = 32'h12345678;
        @(negedge clk);
        wb_i = 1'b0; #1;
        check("r5_rel_vec_m", busy_vec_m, 16'h0000);
        check("r5_rel_err_m", err_m, 1'b0);

        // Register 0: ordinary in the default instance, hardwired in the other
        rsv_i = 1'b1; rsv_regno = 4'd0; #1;
        check("r0_rsvok_m", rsv_ok_m, 1'b1);
        check("r0_rsvok_a", rsv_ok_a, 1'b1);
        @(negedge clk);
        rsv_i = 1'b0; set_rd(4'd0, 4'd0); #1;
        check("r0_vec_m", busy_vec_m, 16'h0001);
        check("r0_vec_a", busy_vec_a, 16'h0000);
        check("r0_rdbusy_m", rd_busy_m, 2'b11);
        check("r0_rdbusy_a", rd_busy_a, 2'b00);
        wb_i = 1'b1; wb_regno = 4'd0; wb_data = 32'hFFFFFFFF; #1;
        check("r0_wb_byp_m", rd_data_m[31:0], 32'hFFFFFFFF);
        check("r0_wb_zero_a", rd_data_a[31:0], 32'h0);
        @(negedge clk);
        wb_i = 1'b0; #1;
        check("r0_data_m", rd_data_m[31:0], 32'hFFFFFFFF);
        check("r0_data_a", rd_data_a[31:0], 32'h0);
        check("r0_after_vec_m", busy_vec_m, 16'h0000);
        check("r0_after_vec_a", busy_vec_a, 16'h0000);
        check("r0_err_m", err_m, 1'b0);
        check("r0_err_a", err_a, 1'b0);

        // Writeback to unreserved r7 sets the sticky error
        wb_i = 1'b1; wb_regno = 4'd7; wb_data = 32'h00000077;
        @(negedge clk);
        wb_i = 1'b0; set_rd(4'd7, 4'd0); #1;
        check("r7_err_m", err_m, 1'b1);
        check("r7_err_a", err_a, 1'b1);
        check("r7_data_m", rd_data_m[31:0], 32'h00000077);
        rsv_i = 1'b1; rsv_regno = 4'd2;
        @(negedge clk);
        rsv_i = 1'b0; wb_i = 1'b1; wb_regno = 4'd2; wb_data = 32'h22;
        @(negedge clk);
        wb_i = 1'b0; #1;
        check("sticky_err_m", err_m, 1'b1);
        check("sticky_err_a", err_a, 1'b1);
        check("sticky_vec_m", busy_vec_m, 16'h0000);

        // Reserve r1, r2, r4; write r4; then asynchronous reset mid-cycle
        rsv_i = 1'b1; rsv_regno = 4'd1;
        @(negedge clk); rsv_regno = 4'd2;
        @(negedge clk); rsv_regno = 4'd4;
        @(negedge clk);
        rsv_i = 1'b0; wb_i = 1'b1; wb_regno = 4'd4; wb_data = 32'hA5A5A5A5;
        @(negedge clk);
        wb_i = 1'b0; set_rd(4'd4, 4'd1); rsv_regno = 4'd1; #1;
        check("pre_rst_data_m", rd_data_m[31:0], 32'hA5A5A5A5);
        check("pre_rst_vec_m", busy_vec_m, 16'h0006);
        check("pre_rst_vec_a", busy_vec_a, 16'h0006);
        check("pre_rst_rdbusy_m", rd_busy_m, 2'b10);
        check("pre_rst_rsvok_m", rsv_ok_m, 1'b0);
        #2 rst = 1'b1; #1;
        check("async_rst_vec_m", busy_vec_m, 16'h0000);
        check("async_rst_vec_a", busy_vec_a, 16'h0000);
        check("async_rst_err_m", err_m, 1'b0);
        check("async_rst_err_a", err_a, 1'b0);
        check("async_rst_rsvok_m", rsv_ok_m, 1'b1);
        check("async_rst_data_m", rd_data_m, 64'h0);
        check("async_rst_data_a", rd_data_a, 64'h0);
        check("async_rst_rdbusy_m", rd_busy_m, 2'b00);

        // Traffic presented during reset is ignored
        wb_i = 1'b1; wb_regno = 4'd4; wb_data = 32'h00001234;
        rsv_i = 1'b1; rsv_regno = 4'd6;
        @(negedge clk);
        wb_i = 1'b0; rsv_i = 1'b0; rst = 1'b0; #1;
        check("post_rst_r4_m", rd_data_m[31:0], 32'h0);
        check("post_rst_r4_a", rd_data_a[31:0], 32'h0);
        check("post_rst_vec_m", busy_vec_m, 16'h0000);
        check("post_rst_vec_a", busy_vec_a, 16'h0000);
        check("post_rst_err_m", err_m, 1'b0);
        @(negedge clk); #1;
        check("post_rst2_vec_m", busy_vec_m, 16'h0000);
        check("post_rst2_r4_m", rd_data_m[31:0], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_scoreboard.md
# register_scoreboard

Parametrised general-purpose register file with a per-register reservation scoreboard, a configurable number of combinational read ports and optional writeback-to-read bypass. It sits between the instruction decoder (read ports, destination reservation) and the writeback stage (write port, reservation release). It replaces a single global "reserved" flag with per-register busy bits, so only instructions that read a pending register have to stall.

## Interface

Parameters:
- LEN_REG, 32, data width of each register.
- LEN_REGNO, 4, register-number width; NUM_REGS = 2**LEN_REGNO.
- NUM_RPORTS, 2, number of read ports (1..4).
- BYPASS, 1, when 1 a same-cycle writeback is forwarded to the read ports and masks busy.
- ZERO_REG, 0, when 1 register 0 always reads 0, is never busy, and ignores writes and reservations.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_regno_i  input  NUM_RPORTS*LEN_REGNO  packed read addresses; port p uses bits [p*LEN_REGNO +: LEN_REGNO].
- rd_data_o  output  NUM_RPORTS*LEN_REG  packed read data, same packing.
- rd_busy_o  output  NUM_RPORTS  port p's register is reserved, and the reservation is not being released by a bypassed writeback.
- rsv_i  input  1  request to reserve a destination register.
- rsv_regno_i  input  LEN_REGNO  register to reserve.
- rsv_ok_o  output  1  reservation can be accepted this cycle.
- wb_i  input  1  writeback strobe.
- wb_regno_i  input  LEN_REGNO  writeback register.
- wb_data_i  input  LEN_REG  writeback data.
- busy_vec_o  output  NUM_REGS  registered reservation bits, bit n = register n.
- err_o  output  1  sticky: a writeback hit an unreserved register.

## Operation

- State: data array NUM_REGS x LEN_REG, reservation vector rsv[NUM_REGS], sticky err.
- Read port p is combinational. Let r = its address:
  - ZERO_REG and r==0: data 0, busy 0.
  - BYPASS and wb_i and wb_regno_i==r: data = wb_data_i, busy 0.
  - Otherwise: data = array[r], busy = rsv[r].
- rsv_ok_o = !rsv[rsv_regno_i], OR (wb_i and wb_regno_i==rsv_regno_i), OR (ZERO_REG and rsv_regno_i==0). It does not depend on rsv_i.
- A reservation is accepted when rsv_i and rsv_ok_o are both 1.
  - Accepted: rsv[rsv_regno_i] is set at the next edge, except register 0 when ZERO_REG.
  - Refused (rsv_i with rsv_ok_o=0): no state change. The requester holds its request and stalls.
- Writeback (wb_i=1):
  - array[wb_regno_i] <= wb_data_i (suppressed for register 0 when ZERO_REG).
  - rsv[wb_regno_i] is cleared.
  - If rsv[wb_regno_i] was 0 before the edge, err is set (suppressed for register 0 when ZERO_REG).
- Writeback and an accepted reservation to the same register in the same cycle: data is written and rsv stays 1. The new reservation wins; no err.
- Writeback and an accepted reservation to different registers: both take effect independently.
- err clears only on rst.
- busy_vec_o = rsv, directly from flops.

## Timing

- Read data, rd_busy_o and rsv_ok_o: zero-latency combinational from inputs and current state.
- Written data is visible through the array one cycle after wb_i. With BYPASS=1 it is already visible in the wb_i cycle.
- Reservation is visible on busy_vec_o and rd_busy_o one cycle after acceptance.
- Reset values while rst=1 and immediately after:
  - array all 0, rsv all 0, err 0.
  - rd_data_o 0 on every port (absent a bypass), rd_busy_o 0, busy_vec_o 0, rsv_ok_o 1, err_o 0.
- Reset asserted mid-operation discards all pending reservations and data in the same cycle, without waiting for a clock edge. Writebacks and reservations presented while rst=1 are ignored.

## Test plan

- Reset then read all 16 registers on both ports: data 0, rd_busy_o 0, busy_vec_o 16'h0000, rsv_ok_o 1, err_o 0.
- Reserve r3; next cycle read r3: rd_busy_o=1, busy_vec_o=16'h0008. rsv_i for r3 again: rsv_ok_o=0 and busy_vec_o unchanged.
- With r3 reserved, wb r3=32'hDEADBEEF:
  - BYPASS=1: same cycle port0 reads DEADBEEF with busy 0; next cycle busy_vec_o=0.
  - BYPASS=0: same cycle port0 reads old data with busy 1; next cycle DEADBEEF.
- Same cycle: wb r5=32'h12345678 plus rsv_i r5 (r5 previously reserved): rsv_ok_o=1; next cycle array r5=12345678, busy_vec_o bit5=1, err_o=0.
- wb to unreserved r7: err_o=1 next cycle and stays 1 through further legal traffic until rst. With ZERO_REG=1, wb and rsv to r0 leave r0 reading 0, busy_vec_o bit0=0 and err_o=0.
- Reserve r1 and r2, write r4=32'hA5A5A5A5, then pulse rst asynchronously between edges: all outputs return to reset values immediately. The first read after reset of r4 returns 0.
